// File: rtl/dcache_miss_unit.sv
// dcache_miss_unit
// Handles one data-cache miss at a time. It picks a victim way from a
// per-set round-robin pointer, writes a dirty victim back to L2, fetches the
// missing line from L2, and hands the line and its way back to the D$.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   miss_req_*            miss request from D$ (ready = unit idle)
//   miss_addr_i           miss physical address
//   victim_way_o          combinational round-robin way for miss_addr_i's set
//   evict_*               victim line state/address/data, sampled with the miss
//   l2_req_*              L2 request channel (we=1 writeback, we=0 line read)
//   l2_resp_*             L2 read data or write acknowledge
//   refill_*              refill line, address and way returned to D$
module dcache_miss_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BYTES = 64,
   parameter int WAYS       = 2,
   parameter int SETS       = 128
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      miss_req_valid_i,
   output logic                      miss_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]     miss_addr_i,
   output logic [$clog2(WAYS)-1:0]   victim_way_o,
   input  logic                      evict_dirty_i,
   input  logic [ADDR_WIDTH-1:0]     evict_addr_i,
   input  logic [LINE_BYTES*8-1:0]   evict_data_i,
   output logic                      l2_req_valid_o,
   input  logic                      l2_req_ready_i,
   output logic                      l2_req_we_o,
   output logic [ADDR_WIDTH-1:0]     l2_req_addr_o,
   output logic [LINE_BYTES*8-1:0]   l2_req_wdata_o,
   input  logic                      l2_resp_valid_i,
   input  logic [LINE_BYTES*8-1:0]   l2_resp_data_i,
   output logic                      refill_valid_o,
   input  logic                      refill_ready_i,
   output logic [ADDR_WIDTH-1:0]     refill_addr_o,
   output logic [$clog2(WAYS)-1:0]   refill_way_o,
   output logic [LINE_BYTES*8-1:0]   refill_data_o
);

   localparam int OFFSET = $clog2(LINE_BYTES);
   localparam int WW     = $clog2(WAYS);
   localparam int INDEX  = $clog2(SETS);
   localparam int DW     = LINE_BYTES * 8;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP
   } state_t;

   state_t                 state_q;
   logic [WW-1:0]          rr_ptr_q [SETS];
   logic                   ready_q;
   logic                   l2_valid_q;
   logic                   l2_we_q;
   logic [ADDR_WIDTH-1:0]  l2_addr_q;
   logic [DW-1:0]          l2_wdata_q;
   logic                   refill_valid_q;
   logic [ADDR_WIDTH-1:0]  miss_addr_q;
   logic [WW-1:0]          way_q;
   logic [DW-1:0]          refill_data_q;

   assign victim_way_o     = rr_ptr_q[miss_addr_i[OFFSET +: INDEX]];

   assign miss_req_ready_o = ready_q;
   assign l2_req_valid_o   = l2_valid_q;
   assign l2_req_we_o      = l2_we_q;
   assign l2_req_addr_o    = l2_addr_q;
   assign l2_req_wdata_o   = l2_wdata_q;
   assign refill_valid_o   = refill_valid_q;
   assign refill_addr_o    = miss_addr_q;
   assign refill_way_o     = way_q;
   assign refill_data_o    = refill_data_q;

   // Outputs are registered: each transition loads the values the next state
   // presents, so ready/valid flags change in the same edge as the state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         ready_q        <= 1'b1;
         l2_valid_q     <= 1'b0;
         l2_we_q        <= 1'b0;
         l2_addr_q      <= '0;
         l2_wdata_q     <= '0;
         refill_valid_q <= 1'b0;
         miss_addr_q    <= '0;
         way_q          <= '0;
         refill_data_q  <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            rr_ptr_q[s] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (miss_req_valid_i) begin
                  ready_q     <= 1'b0;
                  miss_addr_q <= miss_addr_i & LINE_MASK;
                  way_q       <= victim_way_o;
                  l2_valid_q  <= 1'b1;
                  // The evict line is parked in the L2 request registers; a
                  // clean miss goes straight to the line read instead.
                  l2_wdata_q  <= evict_data_i;
                  if (evict_dirty_i) begin
                     state_q   <= WB_REQ;
                     l2_we_q   <= 1'b1;
                     l2_addr_q <= evict_addr_i & LINE_MASK;
                  end else begin
                     state_q   <= RD_REQ;
                     l2_we_q   <= 1'b0;
                     l2_addr_q <= miss_addr_i & LINE_MASK;
                  end
               end
            end
            WB_REQ: begin
               if (l2_req_ready_i) begin
                  l2_valid_q <= 1'b0;
                  state_q    <= WB_WAIT;
               end
            end
            WB_WAIT: begin
               if (l2_resp_valid_i) begin
                  l2_valid_q <= 1'b1;
                  l2_we_q    <= 1'b0;
                  l2_addr_q  <= miss_addr_q;
                  state_q    <= RD_REQ;
               end
            end
            RD_REQ: begin
               if (l2_req_ready_i) begin
                  l2_valid_q <= 1'b0;
                  state_q    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (l2_resp_valid_i) begin
                  refill_data_q  <= l2_resp_data_i;
                  refill_valid_q <= 1'b1;
                  state_q        <= RESP;
               end
            end
            RESP: begin
               if (refill_ready_i) begin
                  refill_valid_q <= 1'b0;
                  ready_q        <= 1'b1;
                  rr_ptr_q[miss_addr_q[OFFSET +: INDEX]] <=
                     rr_ptr_q[miss_addr_q[OFFSET +: INDEX]] + WW'(1);
                  state_q        <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
